// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the architectural PC, keeps at most one word fetch
// outstanding on the req/gnt/rvalid port and presents {pc, instr} to decode from a one-entry slot.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_instr
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [31:0] C_RESET_PC = RESET_PC & 32'hFFFF_FFFC;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_instr;

   logic [31:0] w_target;
   logic [31:0] w_pc_inc;
   logic        w_slot_free;
   logic        w_req;
   logic        w_if_valid;
   logic        w_grant;
   logic        w_pop;

   assign w_target    = i_redirect_pc & 32'hFFFF_FFFC;
   assign w_pc_inc    = r_pc + 32'd4;
   assign w_slot_free = ~r_valid | i_if_ready;
   assign w_grant     = w_req & i_imem_gnt;
   assign w_pop       = w_if_valid & i_if_ready;

   // Request only from REQ, and only when the slot will be empty by the time data returns.
   always_comb begin
      w_req = 1'b0;
      if (r_state == ST_REQ) begin
         w_req = w_slot_free & ~i_redirect & ~i_rst;
      end else begin
         w_req = 1'b0;
      end
   end

   // A slot presented during a redirect is wrong-path and must never reach decode.
   always_comb begin
      w_if_valid = 1'b0;
      if (i_rst || i_redirect) begin
         w_if_valid = 1'b0;
      end else begin
         w_if_valid = r_valid;
      end
   end

   // Fetch FSM, PC and output slot; redirect overrides every other update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_REQ;
         r_pc       <= C_RESET_PC;
         r_valid    <= 1'b0;
         r_if_pc    <= C_RESET_PC;
         r_if_instr <= 32'h0000_0000;
      end else if (i_redirect) begin
         r_pc    <= w_target;
         r_valid <= 1'b0;
         case (r_state)
            ST_REQ:  r_state <= ST_REQ;
            ST_WAIT: r_state <= i_imem_rvalid ? ST_REQ : ST_DROP;
            ST_DROP: r_state <= i_imem_rvalid ? ST_REQ : ST_DROP;
            default: r_state <= ST_REQ;
         endcase
      end else begin
         if (w_pop) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            ST_REQ: begin
               if (w_grant) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The load below wins over a same-cycle pop of the previous entry.
               if (i_imem_rvalid) begin
                  r_valid    <= 1'b1;
                  r_if_pc    <= r_pc;
                  r_if_instr <= i_imem_rdata;
                  r_pc       <= w_pc_inc;
                  r_state    <= ST_REQ;
               end
            end
            ST_DROP: begin
               if (i_imem_rvalid) begin
                  r_state <= ST_REQ;
               end
            end
            default: r_state <= ST_REQ;
         endcase
      end
   end

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_if_valid  = w_if_valid;
   assign o_if_pc     = r_if_pc;
   assign o_if_instr  = r_if_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with random gnt/rvalid delays and a
// stream-level reference (expected delivered PC, expected fetch address) driven by redirects.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic        d2_imem_req;
   logic [31:0] d2_imem_addr;
   logic        d2_if_valid;
   logic [31:0] d2_if_pc;
   logic [31:0] d2_if_instr;

   instr_fetch u_dut (
      .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
      .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
      .o_if_valid(if_valid), .i_if_ready(if_ready), .o_if_pc(if_pc), .o_if_instr(if_instr)
   );

   // Same stimulus, different reset PC: its stream is the first one offset by 0x100.
   instr_fetch #(.RESET_PC(32'h0000_0100)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(d2_imem_req), .o_imem_addr(d2_imem_addr), .i_imem_gnt(imem_gnt),
      .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
      .o_if_valid(d2_if_valid), .i_if_ready(if_ready), .o_if_pc(d2_if_pc), .o_if_instr(d2_if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fail;
   int          ntx;
   int          ntx_start;
   int          k;
   int          last;
   int          found;
   logic [31:0] cap_pc;
   logic [31:0] cap_instr;

   bit          data_mode;
   bit          spur;
   int          g_lo, g_hi, rv_lo, rv_hi;
   int          gnt_cnt, rv_cnt;
   logic        mem_out;
   logic [31:0] mem_addr;
   logic [31:0] exp_pc;
   logic [31:0] exp_fetch;

   logic        s_req, s_valid, s_gnt, s_tx;
   logic [31:0] s_addr, s_pc, s_instr, s_d2_addr, s_d2_pc, s_d2_instr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (data_mode) return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
      else return a;
   endfunction

   // One clock cycle: entered and left at posedge+1; caller has set redirect/if_ready.
   task automatic cycle();
      logic rv_now;
      rv_now      = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      #1;
      if (mem_out && rv_cnt == 0) begin
         rv_now      = 1'b1;
         imem_rvalid = 1'b1;
         imem_rdata  = mem_data(mem_addr);
      end else if (!mem_out && spur && $urandom_range(7, 0) == 0) begin
         imem_rvalid = 1'b1;
      end
      if (imem_req && gnt_cnt == 0) imem_gnt = 1'b1;
      #1;
      s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
      s_pc = if_pc; s_instr = if_instr; s_gnt = imem_req & imem_gnt;
      s_d2_addr = d2_imem_addr; s_d2_pc = d2_if_pc; s_d2_instr = d2_if_instr;
      s_tx = if_valid & if_ready;
      if (redirect) begin
         check_eq("req_in_redirect", {31'd0, s_req}, 32'd0);
         check_eq("valid_in_redirect", {31'd0, s_valid}, 32'd0);
      end
      if (mem_out) check_eq("one_outstanding", {31'd0, s_req}, 32'd0);
      if (s_tx) begin
         check_eq("tx_pc", s_pc, exp_pc);
         check_eq("tx_instr", s_instr, mem_data(exp_pc));
         exp_pc = exp_pc + 32'd4;
         ntx++;
      end
      if (rv_now) mem_out = 1'b0;
      else if (mem_out) rv_cnt--;
      if (imem_req) begin
         if (gnt_cnt == 0) begin
            check_eq("gnt_addr", s_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            mem_out   = 1'b1;
            mem_addr  = s_addr;
            rv_cnt    = $urandom_range(rv_hi, rv_lo);
            gnt_cnt   = $urandom_range(g_hi, g_lo);
         end else begin
            gnt_cnt--;
         end
      end
      if (redirect) begin
         exp_pc    = redirect_pc & 32'hFFFF_FFFC;
         exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      @(posedge clk); #1;
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;
      check_eq("rst_req_hold", {31'd0, imem_req}, 32'd0);
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_if_pc", if_pc, 32'd0);
      check_eq("rst_if_instr", if_instr, 32'd0);
      check_eq("rst_addr", imem_addr, 32'd0);
      check_eq("rst_addr_100", d2_imem_addr, 32'h0000_0100);
      check_eq("rst_if_pc_100", d2_if_pc, 32'h0000_0100);
      rst = 1'b0;
      mem_out = 1'b0; gnt_cnt = 0; rv_cnt = 0;
      exp_pc = 32'd0; exp_fetch = 32'd0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_fail = 0; ntx = 0;
      data_mode = 1'b0; spur = 1'b0;
      g_lo = 0; g_hi = 0; rv_lo = 0; rv_hi = 0;
      mem_out = 1'b0; mem_addr = 32'd0;
      do_reset();

      // Zero-wait streaming from reset, addr-as-data.
      if_ready = 1'b1; k = 0; last = -1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (i == 0) begin
            check_eq("first_req", {31'd0, s_req}, 32'd1);
            check_eq("first_addr", s_addr, 32'd0);
            check_eq("first_addr_100", s_d2_addr, 32'h0000_0100);
         end
         if (s_tx) begin
            if (k == 0) check_eq("first_latency", i, 32'd2);
            else check_eq("throughput", i - last, 32'd2);
            check_eq("seq_pc", s_pc, 4 * k);
            check_eq("pc_100", s_d2_pc, s_pc + 32'h100);
            check_eq("instr_100", s_d2_instr, s_pc);
            last = i; k++;
         end
      end
      check_eq("stream_count", k, 32'd5);

      // Backpressure with the slot full.
      if_ready = 1'b0; found = 0;
      for (int i = 0; i < 6 && found == 0; i++) begin
         cycle();
         if (s_valid) found = 1;
      end
      check_eq("bp_fill", found, 32'd1);
      cap_pc = s_pc; cap_instr = s_instr;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_eq("bp_req", {31'd0, s_req}, 32'd0);
         check_eq("bp_valid", {31'd0, s_valid}, 32'd1);
         check_eq("bp_pc", s_pc, cap_pc);
         check_eq("bp_instr", s_instr, cap_instr);
      end
      if_ready = 1'b1;
      cycle();
      check_eq("bp_release_req", {31'd0, s_req}, 32'd1);
      check_eq("bp_release_tx", {31'd0, s_tx}, 32'd1);

      // Redirect to 0x403 while a fetch is outstanding; its rvalid lands 3 cycles later.
      rv_lo = 3; rv_hi = 3; found = 0;
      for (int i = 0; i < 6 && found == 0; i++) begin
         cycle();
         if (s_gnt) found = 1;
      end
      check_eq("wait_gnt", found, 32'd1);
      rv_lo = 0; rv_hi = 0;
      redirect = 1'b1; redirect_pc = 32'h0000_0403;
      cycle();
      redirect = 1'b0;
      found = 0; k = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (s_gnt && found == 0) begin
            found = 1;
            check_eq("redir_gnt_addr", s_addr, 32'h0000_0400);
            check_eq("redir_gnt_cycle", i, 32'd3);
         end
         if (s_tx && k == 0) begin
            k = 1;
            check_eq("redir_if_pc", s_pc, 32'h0000_0400);
         end
      end
      check_eq("redir_seen", found + k, 32'd2);

      // Redirect with the slot full and decode ready in the same cycle.
      if_ready = 1'b0; found = 0;
      for (int i = 0; i < 6 && found == 0; i++) begin
         cycle();
         if (s_valid) found = 1;
      end
      check_eq("sq_fill", found, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0000_0800; if_ready = 1'b1;
      cycle();
      check_eq("sq_valid", {31'd0, s_valid}, 32'd0);
      redirect = 1'b0;
      cycle();
      check_eq("sq_cleared", {31'd0, s_valid}, 32'd0);
      check_eq("sq_req", {31'd0, s_req}, 32'd1);
      check_eq("sq_addr", s_addr, 32'h0000_0800);

      // PC wrap at the top of the address space.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect = 1'b0; k = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (s_tx) begin
            if (k == 0) check_eq("wrap_pc0", s_pc, 32'hFFFF_FFFC);
            if (k == 1) check_eq("wrap_pc1", s_pc, 32'h0000_0000);
            k++;
         end
      end
      check_eq("wrap_count", {31'd0, (k >= 2)}, 32'd1);

      // Randomised gnt/rvalid delays, backpressure and redirects; redirect squashes old-mode data.
      data_mode = 1'b1; spur = 1'b1;
      g_lo = 0; g_hi = 4; rv_lo = 0; rv_hi = 4;
      redirect = 1'b1; redirect_pc = $urandom; if_ready = 1'b1;
      cycle();
      redirect = 1'b0;
      ntx_start = ntx;
      for (int i = 0; i < 3000; i++) begin
         if_ready = ($urandom_range(3, 0) != 0);
         redirect = ($urandom_range(19, 0) == 0);
         redirect_pc = $urandom;
         if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15, 0);
         cycle();
      end
      redirect = 1'b0;
      check_eq("rand_progress", {31'd0, ((ntx - ntx_start) > 100)}, 32'd1);

      // Reset mid-stream, then resume from RESET_PC.
      do_reset();
      data_mode = 1'b0; spur = 1'b0;
      g_lo = 0; g_hi = 0; rv_lo = 0; rv_hi = 0;
      if_ready = 1'b1; k = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (s_tx && k == 0) begin
            k = 1;
            check_eq("post_rst_pc", s_pc, 32'd0);
         end
      end
      check_eq("post_rst_tx", k, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue 32-bit CPU. It owns the architectural PC register and issues word fetches to instruction memory over a req/gnt/rvalid interface. It hands each fetched instruction with its PC to decode over a valid/ready handshake. It takes the branch/jump target (nextPC) from the PC-select logic on a redirect strobe, and squashes any wrong-path fetch in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- redirect  input  1  taken branch/jump this cycle; load redirect_pc
- redirect_pc  input  32  target PC from PC select; bits [1:0] ignored (forced 00)
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch word address (byte address, [1:0]=00)
- imem_gnt  input  1  request accepted this cycle when imem_req & imem_gnt
- imem_rvalid  input  1  read data valid; exactly one per granted request, earliest the cycle after gnt
- imem_rdata  input  32  instruction word
- if_valid  output  1  instruction available to decode
- if_ready  input  1  decode accepts; transfer when if_valid & if_ready
- if_pc  output  32  PC of presented instruction
- if_instr  output  32  presented instruction

## Operation
- Registers: pc (next fetch address), state, output slot {valid_q, if_pc, if_instr}.
- States:
  - REQ: no fetch outstanding.
    - imem_req = (~valid_q | if_ready) & ~redirect. imem_addr = pc.
    - On req & gnt: go to WAIT.
  - WAIT: one fetch outstanding for address pc.
    - On rvalid: load slot with {1, pc, imem_rdata}; pc <= pc + 4; go to REQ.
  - DROP: one wrong-path fetch outstanding.
    - imem_req = 0.
    - On rvalid: discard data; go to REQ.
- Request gating guarantees the output slot is empty when a response arrives. There is no skid buffer.
- While ungranted, imem_req/imem_addr may change or drop (redirect); the memory must not depend on them being stable.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2], 2'b00}; valid_q <= 0.
  - REQ without a same-cycle grant → stays REQ. Redirect also forces imem_req low that cycle, so no grant can coincide with a redirect.
  - WAIT without rvalid → DROP. WAIT with rvalid → response discarded, REQ.
  - DROP without rvalid → stays DROP (pc updated). DROP with rvalid → REQ.
- if_valid = valid_q & ~redirect. A slot transfer coinciding with redirect is squashed, and decode must not consume it.
- Slot pop: valid_q <= 0 on if_valid & if_ready, unless loaded the same cycle.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- imem_rvalid in state REQ (no outstanding fetch) is ignored.

## Timing
- Reset, while rst = 1 and on the following edge: state = REQ, pc = RESET_PC, valid_q = 0, if_pc = RESET_PC, if_instr = 0. imem_req is forced 0 while rst = 1. imem_addr = RESET_PC.
- Reset mid-operation: any outstanding fetch is abandoned. Memory shares rst, so no stale rvalid follows.
- First req: the cycle after rst deasserts.
- Latency with gnt in cycle N and rvalid in cycle N+1: if_valid in N+2, next req in N+2 if if_ready = 1.
- Peak throughput: one instruction per 2 cycles.
- Redirect in cycle N with a zero-wait memory: first request to the target in cycle N+1, or on the cycle after the dropped rvalid.
- All outputs are registered except imem_req and if_valid, which are combinational from state/slot, if_ready and redirect.

## Test plan
- Reset then zero-wait memory returning addr-as-data, if_ready = 1:
  - Required: if_pc = 0, 4, 8, 12 with if_instr equal to if_pc; one transfer every 2 cycles; RESET_PC = 0x100 starts at 0x100.
- Backpressure: if_ready = 0 for 5 cycles with slot full.
  - Required: imem_req = 0 throughout, if_pc/if_instr stable.
  - If_ready = 1 in the same cycle → imem_req = 1 in that cycle.
- Redirect to 0x0000_0403 while in WAIT, rvalid 3 cycles later:
  - Required: stale data never appears on if_valid; next granted imem_addr = 0x400; if_pc = 0x400.
- Redirect with slot full and if_ready = 1 in the same cycle:
  - Required: if_valid = 0 that cycle; slot cleared; next fetch from target.
- Wrap: redirect to 0xFFFF_FFFC.
  - Required: if_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- Random gnt/rvalid delays (0–4 cycles) with random if_ready and redirects; a scoreboard checks:
  - each delivered (if_pc, if_instr) matches the memory model;
  - PCs are sequential between redirects;
  - at most one fetch is outstanding at any time.
